// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the 16-bit RISC core.
// Optional memory-handshake timeout with sticky fault is enabled by defining SEQ_MEM_TIMEOUT_EN.
module cpu_seq_ctrl #(
   parameter logic [15:0] RESET_PC       = 16'h0000,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [15:0] pc,
   input  logic        dec_we,
   input  logic        dec_ls,
   input  logic [15:0] dec_pc,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   input  logic        halt,
   output logic        halted,
   output logic        fault
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_FAULT  = 3'd7;

   logic [2:0]  state_q, state_d;
   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic        rf_we_q, rf_we_d;

`ifdef SEQ_MEM_TIMEOUT_EN
   localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW     = (CW_RAW < 4) ? 4 : CW_RAW;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt_q;
   logic          timed_out;

   assign timed_out = (wait_cnt_q == LAST_WAIT);

   // Counts cycles spent waiting in FETCH/MEM; zero on every entry since neither follows itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else if (state_q == S_FETCH || state_q == S_MEM) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
         wait_cnt_q <= '0;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = halt ? S_HALT : S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               state_d = S_DECODE;
`ifdef SEQ_MEM_TIMEOUT_EN
            end else if (timed_out) begin
               state_d = S_FAULT;
`endif
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = dec_ls ? S_MEM : S_WB;
         S_MEM: begin
            if (dmem_ack) begin
               state_d = S_WB;
`ifdef SEQ_MEM_TIMEOUT_EN
            end else if (timed_out) begin
               state_d = S_FAULT;
`endif
            end
         end
         S_WB:     state_d = halt ? S_HALT : S_FETCH;
         S_HALT:   state_d = halt ? S_HALT : S_FETCH;
`ifdef SEQ_MEM_TIMEOUT_EN
         S_FAULT:  state_d = S_FAULT;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   // Strobe is registered on entry to WB so it never follows the decoder inputs combinationally.
   assign rf_we_d = (state_d == S_WB) & dec_we & ~(dec_ls & ~instr_q[11]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
         rf_we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rf_we_q <= rf_we_d;
         if (state_q == S_FETCH && imem_ack) begin
            instr_q <= imem_rdata;
         end
         if (state_q == S_WB) begin
            pc_q <= dec_pc;
         end
      end
   end

   assign imem_req  = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign pc        = pc_q;
   assign dmem_req  = (state_q == S_MEM);
   assign dmem_we   = (state_q == S_MEM) & ~instr_q[11];
   assign rf_we     = rf_we_q;
   assign halted    = (state_q == S_HALT);
`ifdef SEQ_MEM_TIMEOUT_EN
   assign fault     = (state_q == S_FAULT);
`else
   assign fault     = 1'b0;
`endif

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control sequencer for the 16-bit RISC core. It owns the program counter and instruction register and drives the instruction-memory and data-memory request/acknowledge handshakes. It steps each instruction through fetch, decode, execute, optional memory access and write-back, using the control fields produced by the combinational instruction decoder. It also generates the single-cycle register-file write strobe and supports an external halt request.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, maximum wait cycles per memory handshake. Used only when SEQ_MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  16  fetch address, equal to pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  fetched instruction.
- instr  out  16  instruction register, fed to the decoder.
- pc  out  16  current program counter, fed to the decoder as oldpc.
- dec_we  in  1  decoder register write enable.
- dec_ls  in  1  decoder load/store flag.
- dec_pc  in  16  decoder next-PC value (sequential or branch target).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load. Valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe, one cycle wide.
- halt  in  1  stop request, level sensitive.
- halted  out  1  core is parked in HALT.
- fault  out  1  sticky memory-timeout fault.

Reset values: instr=0, pc=RESET_PC, fault=0. All other outputs reset to 0.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, and FAULT (FAULT exists only when SEQ_MEM_TIMEOUT_EN is defined).

State behaviour:
- IDLE: reset state; all outputs are 0. Next state is HALT if halt=1, otherwise FETCH.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack. On the ack edge, instr is loaded from imem_rdata and the next state is DECODE.
- DECODE: one cycle, giving the decoder outputs time to settle. Next state is EXEC.
- EXEC: one cycle. Next state is MEM if dec_ls=1, otherwise WB.
- MEM: dmem_req=1 and dmem_we=~instr[11], both held until dmem_ack. Next state is WB.
- WB: rf_we = dec_we & ~(dec_ls & ~instr[11]), so stores never write the register file. pc is loaded from dec_pc. Next state is HALT if halt=1, otherwise FETCH.
- HALT: halted=1 and no requests are issued. Returns to FETCH on the first cycle halt=0; pc is unchanged.

Rules:
- halt is sampled only in IDLE and WB. An instruction in flight always completes.
- pc arithmetic is modulo 2^16; 16'hFFFF followed by a sequential step gives 16'h0000. The sequencer adds nothing itself and takes dec_pc as given.
- instr and pc change only on the FETCH ack edge and in WB respectively.
- A reset asserted mid-operation forces IDLE immediately. Any outstanding req drops asynchronously and the memory side discards it.
- An ack received outside FETCH or MEM, or while the relevant req is low, is ignored.
- All outputs are registered or decoded from the state register (Moore outputs). No output depends combinationally on an input.

## Timing
- Handshake ack is sampled on the rising edge while req is high. The minimum FETCH and MEM duration is 1 cycle each.
- With zero-wait memory:
  - ALU, move and branch instructions take 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load and store instructions take 5 cycles.
- Each wait cycle on imem_ack or dmem_ack adds 1 cycle.
- rf_we is high for exactly one cycle, in WB. The new pc is visible the cycle after WB, which is the first FETCH cycle.
- From halt asserted during WB: halted=1 on the next cycle. From halt deasserted: imem_req=1 on the next cycle.

## Configuration
SEQ_MEM_TIMEOUT_EN
- Defined:
  - A 4-bit-or-wider wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, the next state is FAULT: req drops, fault=1.
  - FAULT is left only by reset.
- Undefined:
  - The sequencer waits indefinitely for ack.
  - fault is tied to 0, and the counter and FAULT state are absent.

## Test plan
- Reset release with halt=0 and zero-wait imem returning ADDS r2,r1,r0 (16'h1802), dec_we=1, dec_pc=1: imem_req rises one cycle after IDLE; rf_we pulses in cycle 4 after FETCH entry; pc=1 on the next cycle.
- Store with dec_ls=1, instr[11]=0, dec_we=1, and dmem_ack delayed 3 cycles: dmem_we=1 for 4 cycles; rf_we stays 0 through WB; total 8 cycles.
- Branch with dec_pc=16'h0040 and pc=16'h0010: the next imem_addr is 16'h0040. Sequential step from pc=16'hFFFF with dec_pc=16'h0000: the next imem_addr is 16'h0000.
- halt asserted during EXEC: the instruction completes, halted=1 the cycle after WB, and no imem_req is issued. halt released: imem_req=1 the next cycle with pc unchanged.
- rst_n pulsed low during MEM with dmem_req=1: dmem_req drops immediately, pc returns to RESET_PC, and a spurious dmem_ack after release is ignored.
- SEQ_MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, imem_ack held low: fault=1 and imem_req=0 after 15 wait cycles, held until reset. The same test with the macro undefined: imem_req stays high and fault stays 0.
